me_req_master: RTL and testbench

//   Host-side initiator for the motion-estimation core's req/ack port. Runs
//   one ME search per macroblock for a frame of NUM_BLK blocks using a

---
 rtl/me_pkg.sv | 28 ++
 rtl/me_hs_timeout.sv | 24 ++
 rtl/me_req_master.sv | 133 +++++++++++++
 tb/tb_me_req_master.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/me_pkg.sv
// Shared types and result-word helpers for the motion-estimation host interface.
package me_pkg;
   localparam int SAD_W  = 16;
   localparam int MVEC_W = 10;
   localparam int RES_W  = SAD_W + MVEC_W;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_REQ  = 3'd1,
      ST_CAPT = 3'd2,
      ST_REL  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } me_state_t;

   function automatic logic [RES_W-1:0] res_pack(input logic [MVEC_W-1:0] mvec,
                                                 input logic [SAD_W-1:0]  sad);
      return {mvec, sad};
   endfunction

   function automatic logic [SAD_W-1:0] res_sad(input logic [RES_W-1:0] res);
      return res[SAD_W-1:0];
   endfunction

   function automatic logic [MVEC_W-1:0] res_mvec(input logic [RES_W-1:0] res);
      return res[RES_W-1:SAD_W];
   endfunction
endpackage

// File: rtl/me_hs_timeout.sv
// Handshake phase timer: cleared on phase entry, counts while enabled, flags
// expiry once TIMEOUT-1 is reached.
module me_hs_timeout #(
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 13
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + TO_W'(1);
      end
   end

   assign expired = (cnt == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/me_req_master.sv
// Frame sequencer for the ME core: one four-phase req/ack search per block,
// result write-back, running SAD total and best-block tracking.
module me_req_master
   import me_pkg::*;
#(
   parameter int NUM_BLK = 16,
   parameter int BLK_W   = 4,
   parameter int TIMEOUT = 4096,
   parameter int TO_W    = 13
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   output logic                   busy,
   output logic                   done,
   output logic                   err_timeout,
   output logic                   me_req,
   input  logic                   me_ack,
   input  logic [SAD_W-1:0]       me_min_sad,
   input  logic [MVEC_W-1:0]      me_min_mvec,
   output logic [BLK_W-1:0]       blk_idx,
   output logic                   res_we,
   output logic [BLK_W-1:0]       res_addr,
   output logic [RES_W-1:0]       res_data,
   output logic [SAD_W+BLK_W-1:0] sad_total,
   output logic [BLK_W-1:0]       best_blk,
   output logic [SAD_W-1:0]       best_sad
);
   me_state_t         state, state_nx;
   logic              to_expired;
   logic              to_clr;
   logic              to_en;
   logic              last_blk;
   logic [SAD_W-1:0]  cap_sad_p0;
   logic [MVEC_W-1:0] cap_mvec_p0;

   assign last_blk = (blk_idx == BLK_W'(NUM_BLK - 1));
   assign to_clr   = (state != state_nx);
   assign to_en    = (state == ST_REQ) || (state == ST_REL);

   me_hs_timeout #(
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (to_clr),
      .en      (to_en),
      .expired (to_expired)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      res_we   = 1'b0;
      case (state)
         ST_IDLE: if (start) state_nx = ST_REQ;
         ST_REQ: begin
            busy = 1'b1;
            if (me_ack)          state_nx = ST_CAPT;
            else if (to_expired) state_nx = ST_ERR;
         end
         ST_CAPT: begin
            busy     = 1'b1;
            res_we   = 1'b1;
            state_nx = ST_REL;
         end
         ST_REL: begin
            busy = 1'b1;
            if (!me_ack)         state_nx = last_blk ? ST_DONE : ST_REQ;
            else if (to_expired) state_nx = ST_ERR;
         end
         ST_DONE: begin
            done     = 1'b1;
            state_nx = ST_IDLE;
         end
         ST_ERR:  state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Capture stage: results latched on ack, accumulated in CAPT
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         me_req      <= 1'b0;
         err_timeout <= 1'b0;
         blk_idx     <= '0;
         cap_sad_p0  <= '0;
         cap_mvec_p0 <= '0;
         sad_total   <= '0;
         best_blk    <= '0;
         best_sad    <= '1;
      end else begin
         me_req <= (state_nx == ST_REQ) || (state_nx == ST_CAPT);
         if (state_nx == ST_ERR) err_timeout <= 1'b1;
         case (state)
            ST_IDLE: if (start) begin
               err_timeout <= 1'b0;
               blk_idx     <= '0;
               sad_total   <= '0;
               best_blk    <= '0;
               best_sad    <= '1;
            end
            ST_REQ: if (me_ack) begin
               cap_sad_p0  <= me_min_sad;
               cap_mvec_p0 <= me_min_mvec;
            end
            ST_CAPT: begin
               sad_total <= sad_total + (SAD_W+BLK_W)'(cap_sad_p0);
               // Strict compare so a tie keeps the earlier block
               if (cap_sad_p0 < best_sad) begin
                  best_sad <= cap_sad_p0;
                  best_blk <= blk_idx;
               end
            end
            ST_REL: if (!me_ack && !last_blk) blk_idx <= blk_idx + BLK_W'(1);
            default: ;
         endcase
      end
   end

   assign res_addr = blk_idx;
   assign res_data = res_pack(cap_mvec_p0, cap_sad_p0);
endmodule

// File: tb/tb_me_req_master.sv
// Directed bench for me_req_master: responder model, handshake monitor and
// hand-computed expectations for frame, timeout, reset and restart cases.
module tb_me_req_master;
   localparam int NB      = 4;
   localparam int BW      = 4;
   localparam int ACK_DLY = 3;

   logic          clk = 1'b0;
   logic          rst_n, start, busy, done, err_timeout, me_req, me_ack;
   logic [15:0]   me_min_sad;
   logic [9:0]    me_min_mvec;
   logic [BW-1:0] blk_idx, res_addr, best_blk;
   logic          res_we;
   logic [25:0]   res_data;
   logic [19:0]   sad_total;
   logic [15:0]   best_sad;

   logic [15:0] sad_tab  [0:15];
   logic [9:0]  mvec_tab [0:15];
   int          stall_blk = 99;
   int          ack_hold  = 0;
   bit          mon_clr   = 1'b0;

   int          n_chk = 0, n_fail = 0;
   int          wr_cnt, done_cnt, rise_viol, fall_viol, lat_viol, req_run, last_run;
   int          wr_addr [0:15];
   logic [25:0] wr_data [0:15];

   always #5 clk = ~clk;

   me_req_master #(.NUM_BLK(NB), .BLK_W(BW), .TIMEOUT(64), .TO_W(7)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .err_timeout(err_timeout), .me_req(me_req), .me_ack(me_ack),
      .me_min_sad(me_min_sad), .me_min_mvec(me_min_mvec), .blk_idx(blk_idx),
      .res_we(res_we), .res_addr(res_addr), .res_data(res_data),
      .sad_total(sad_total), .best_blk(best_blk), .best_sad(best_sad)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Responder: ack ACK_DLY cycles after req, hold ack ack_hold cycles past req drop
   initial begin
      int dly, hold;
      me_ack = 1'b0; me_min_sad = 16'hDEAD; me_min_mvec = 10'h3FF;
      dly = 0; hold = 0;
      forever begin
         @(negedge clk);
         if (!me_ack) begin
            hold = 0;
            if (me_req && (int'(blk_idx) != stall_blk)) begin
               dly++;
               if (dly >= ACK_DLY) begin
                  me_ack = 1'b1;
                  me_min_sad  = sad_tab[blk_idx];
                  me_min_mvec = mvec_tab[blk_idx];
               end
            end else begin
               dly = 0;
            end
         end else if (!me_req) begin
            if (hold >= ack_hold) begin
               me_ack = 1'b0; dly = 0;
               me_min_sad = 16'hDEAD; me_min_mvec = 10'h3FF;
            end else begin
               hold++;
            end
         end
      end
   end

   // Monitor: write log, done count, handshake and latency rules
   initial begin
      bit prev_req, prev_ack, ack_seen, pend_drop;
      prev_req = 0; prev_ack = 0; ack_seen = 0; pend_drop = 0;
      wr_cnt = 0; done_cnt = 0; rise_viol = 0; fall_viol = 0; lat_viol = 0;
      req_run = 0; last_run = 0;
      forever begin
         @(posedge clk); #1;
         if (mon_clr) begin
            wr_cnt = 0; done_cnt = 0; rise_viol = 0; fall_viol = 0; lat_viol = 0;
            req_run = 0; last_run = 0;
         end
         if (res_we) begin
            if (wr_cnt < 16) begin wr_addr[wr_cnt] = int'(res_addr); wr_data[wr_cnt] = res_data; end
            wr_cnt++;
         end
         if (done) done_cnt++;
         if (me_req && !prev_req) begin
            if (me_ack) rise_viol++;
            ack_seen = 0;
         end
         if (!me_req && prev_req && !ack_seen && rst_n && !err_timeout) fall_viol++;
         if (me_req && me_ack) ack_seen = 1;
         if (me_ack && !prev_ack) begin
            if (!(res_we && me_req)) lat_viol++;
            pend_drop = 1;
         end else if (pend_drop) begin
            if (me_req) lat_viol++;
            pend_drop = 0;
         end
         if (me_req) req_run++;
         else if (prev_req) begin last_run = req_run; req_run = 0; end
         prev_req = me_req; prev_ack = me_ack;
      end
   end

   task automatic clear_mon();
      @(negedge clk); mon_clr = 1'b1;
      @(negedge clk); mon_clr = 1'b0;
   endtask

   task automatic kick();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_frame(input bit kick_mid, input bit kick_done);
      int n; bit fin, mid_sent;
      n = 0; fin = 0; mid_sent = 0;
      while (!fin && n < 500) begin
         @(negedge clk);
         n++;
         start = 1'b0;
         if (kick_mid && !mid_sent && busy && blk_idx == 2) begin start = 1'b1; mid_sent = 1; end
         if (done || err_timeout) begin
            fin = 1;
            if (kick_done && done) start = 1'b1;
         end
      end
      @(negedge clk);
      start = 1'b0;
      check_eq("frame_bound", fin, 1);
      repeat (3) @(negedge clk);
   endtask

   task automatic check_frame(input string tag);
      check_eq({tag, "_wr_cnt"}, wr_cnt, NB);
      for (int i = 0; i < NB; i++) begin
         check_eq($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
         check_eq($sformatf("%s_data%0d", tag, i), wr_data[i], {mvec_tab[i], sad_tab[i]});
      end
      check_eq({tag, "_sad_total"}, sad_total, 1640);
      check_eq({tag, "_best_blk"}, best_blk, 1);
      check_eq({tag, "_best_sad"}, best_sad, 120);
      check_eq({tag, "_done_cnt"}, done_cnt, 1);
      check_eq({tag, "_busy"}, busy, 0);
      check_eq({tag, "_hs_rise"}, rise_viol, 0);
      check_eq({tag, "_hs_fall"}, fall_viol, 0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 16; i++) begin sad_tab[i] = 16'd0; mvec_tab[i] = 10'd0; end
      sad_tab[0] = 16'd500; sad_tab[1] = 16'd120; sad_tab[2] = 16'd120; sad_tab[3] = 16'd900;
      mvec_tab[0] = 10'h021; mvec_tab[1] = 10'h3E5; mvec_tab[2] = 10'h155; mvec_tab[3] = 10'h2AA;
      rst_n = 1'b0; start = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_err", err_timeout, 0);
      check_eq("rst_req", me_req, 0);
      check_eq("rst_res_data", res_data, 0);
      check_eq("rst_sad_total", sad_total, 0);
      check_eq("rst_best_sad", best_sad, 16'hFFFF);
      rst_n = 1'b1;

      // Normal frame with start latency and ack-to-write latency
      clear_mon();
      start = 1'b1;
      @(posedge clk); #1;
      check_eq("start_req_lat", me_req, 1);
      check_eq("start_busy_lat", busy, 1);
      @(negedge clk); start = 1'b0;
      run_frame(0, 0);
      check_frame("f1");
      check_eq("f1_lat", lat_viol, 0);

      // Ack held high after req drop
      ack_hold = 5;
      clear_mon();
      kick();
      run_frame(0, 0);
      check_frame("f2");
      ack_hold = 0;

      // Responder stalls on block 2
      stall_blk = 2;
      clear_mon();
      kick();
      run_frame(0, 0);
      check_eq("to_err", err_timeout, 1);
      check_eq("to_req", me_req, 0);
      check_eq("to_busy", busy, 0);
      check_eq("to_done_cnt", done_cnt, 0);
      check_eq("to_wr_cnt", wr_cnt, 2);
      check_eq("to_addr0", wr_addr[0], 0);
      check_eq("to_addr1", wr_addr[1], 1);
      check_eq("to_req_run", last_run, 64);
      check_eq("to_sad_total", sad_total, 620);
      check_eq("to_hs_fall", fall_viol, 0);
      stall_blk = 99;

      // Reset two cycles into REQ of block 1
      clear_mon();
      kick();
      check_eq("err_clear", err_timeout, 0);
      n = 0;
      while (!(blk_idx == 1 && me_req) && n < 100) begin @(posedge clk); #1; n++; end
      check_eq("rst_reach", n < 100, 1);
      @(negedge clk);
      @(negedge clk); rst_n = 1'b0;
      @(posedge clk); #1;
      check_eq("mid_rst_req", me_req, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_blk", blk_idx, 0);
      check_eq("mid_rst_sad_total", sad_total, 0);
      check_eq("mid_rst_best_sad", best_sad, 16'hFFFF);
      check_eq("mid_rst_best_blk", best_blk, 0);
      check_eq("mid_rst_res_data", res_data, 0);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_start_busy", busy, 0);
      check_eq("rst_start_req", me_req, 0);
      clear_mon();
      kick();
      check_eq("rerun_blk", blk_idx, 0);
      run_frame(0, 0);
      check_frame("f3");

      // Start pulses mid-frame and on the DONE cycle
      clear_mon();
      kick();
      run_frame(1, 1);
      check_frame("f4");
      check_eq("f4_req", me_req, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
